// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding an 8N1 UART transmitter for the host link.
// Software polls tbre/tsre, writes bytes with wr_en, and frames leave on tx.
module uart_tx_fifo #(
    parameter int unsigned CLK_DIV    = 96,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       tx,
    output logic       tbre,
    output logic       tsre,
    output logic       full
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLK_DIV - 1);
    localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [AW:0]     count;
    logic [AW:0]     count_nx;
    logic [CW-1:0]   baud;
    logic [2:0]      bit_idx;
    logic [2:0]      bit_nx;
    logic [7:0]      shift;
    logic            push;
    logic            pop;
    logic            baud_done;
    logic            going_idle;

    assign full      = (count == FULL_CNT);
    assign tbre      = ~full;
    assign push      = wr_en && !full;
    assign baud_done = (baud == BAUD_LAST);
    assign bit_nx    = bit_idx + 3'd1;

    // Pop decision, FIFO occupancy after this edge, and whether the FSM lands in IDLE.
    always_comb begin
        pop        = 1'b0;
        going_idle = 1'b0;
        count_nx   = count;
        if (count != '0) begin
            if (state == IDLE || (state == STOP && baud_done))
                pop = 1'b1;
        end
        if (state == IDLE && !pop)
            going_idle = 1'b1;
        if (state == STOP && baud_done && !pop)
            going_idle = 1'b1;
        if (push && !pop)
            count_nx = count + 1'b1;
        else if (!push && pop)
            count_nx = count - 1'b1;
    end

    // Buffer storage; no reset needed since pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    // FIFO bookkeeping plus transmit FSM with registered tx and tsre.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
            tsre    <= 1'b1;
        end else begin
            count <= count_nx;
            tsre  <= going_idle && (count_nx == '0);
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                shift  <= mem[rd_ptr];
                rd_ptr <= rd_ptr + 1'b1;
            end
            // tx is loaded with the level of the state being entered, so it
            // changes on the same edge as the state register.
            case (state)
                IDLE: begin
                    baud <= '0;
                    tx   <= 1'b1;
                    if (pop) begin
                        state <= START;
                        tx    <= 1'b0;
                    end
                end
                START: begin
                    if (baud_done) begin
                        baud    <= '0;
                        bit_idx <= '0;
                        state   <= DATA;
                        tx      <= shift[0];
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_nx;
                            tx      <= shift[bit_nx];
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_done) begin
                        baud <= '0;
                        if (pop) begin
                            state <= START;
                            tx    <= 1'b0;
                        end else begin
                            state <= IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        baud <= baud + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed bench for uart_tx_fifo at CLK_DIV=4, FIFO_DEPTH=4.
module tb_uart_tx_fifo;

    localparam int unsigned DIV   = 4;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       tx;
    logic       tbre;
    logic       tsre;
    logic       full;

    int n_cmp = 0;
    int n_bad = 0;

    uart_tx_fifo #(.CLK_DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
        .tx(tx), .tbre(tbre), .tsre(tsre), .full(full)
    );

    always #5 clk = ~clk;

    // Line receiver: samples tx at negedge, mid-bit, and collects decoded bytes.
    logic       rst_q = 1'b1;
    logic       rx_busy = 1'b0;
    int         rx_cyc = 0;
    int         rx_bad = 0;
    logic [7:0] rx_sh = 8'h00;
    logic [7:0] rx_q[$];

    always @(posedge clk) rst_q <= rst;

    always @(negedge clk) begin
        if (rst_q) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (!tx) begin
                rx_busy = 1'b1;
                rx_cyc  = 0;
            end
        end else begin
            rx_cyc++;
            if (rx_cyc >= int'(DIV + DIV / 2) && rx_cyc < int'(9 * DIV) &&
                ((rx_cyc - int'(DIV / 2)) % int'(DIV)) == 0)
                rx_sh = {tx, rx_sh[7:1]};
            if (rx_cyc == int'(9 * DIV + DIV / 2)) begin
                if (tx !== 1'b1) rx_bad++;
                rx_q.push_back(rx_sh);
                rx_busy = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the edge that first drives the start bit.
    task automatic check_frame(input logic [7:0] b);
        logic exp;
        for (int i = 0; i < int'(10 * DIV); i++) begin
            int pos;
            pos = i / int'(DIV);
            if (pos == 0)      exp = 1'b0;
            else if (pos == 9) exp = 1'b1;
            else               exp = b[pos-1];
            check("frame_tx", {31'd0, tx}, {31'd0, exp});
            tick();
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (tsre) break;
            tick();
        end
        check("idle_wait", {31'd0, tsre}, 32'd1);
    endtask

    task automatic check_rx(input string tag, input logic [7:0] first, input int n);
        check({tag, "_count"}, rx_q.size(), n);
        for (int i = 0; i < n && i < rx_q.size(); i++)
            check({tag, "_byte"}, {24'd0, rx_q[i]}, {24'd0, first + 8'(i)});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1;
        tick();
        tick();
        rst = 1'b0;

        // Idle after reset.
        for (int i = 0; i < 20; i++) begin
            check("rst_tx", {31'd0, tx}, 32'd1);
            check("rst_tbre", {31'd0, tbre}, 32'd1);
            check("rst_tsre", {31'd0, tsre}, 32'd1);
            check("rst_full", {31'd0, full}, 32'd0);
            tick();
        end

        // Single byte 0x55 with exact timing.
        wr_en = 1'b1; wr_data = 8'h55;
        tick();
        wr_en = 1'b0;
        check("w55_tsre_low", {31'd0, tsre}, 32'd0);
        check("w55_tx_still_high", {31'd0, tx}, 32'd1);
        tick();
        check_frame(8'h55);
        check("w55_tsre_back", {31'd0, tsre}, 32'd1);
        check("w55_tx_idle", {31'd0, tx}, 32'd1);

        // Back-to-back frames without a gap.
        wr_en = 1'b1; wr_data = 8'hA3;
        tick();
        wr_data = 8'h0F;
        tick();
        wr_en = 1'b0;
        check_frame(8'hA3);
        check_frame(8'h0F);
        check("b2b_tsre", {31'd0, tsre}, 32'd1);

        // Six writes on consecutive edges: fifth fills, sixth dropped.
        rx_q.delete();
        for (int i = 0; i < 6; i++) begin
            wr_en = 1'b1; wr_data = 8'(i + 1);
            tick();
            if (i == 2) check("six_full_early", {31'd0, full}, 32'd0);
            if (i == 4) begin
                check("six_full", {31'd0, full}, 32'd1);
                check("six_tbre", {31'd0, tbre}, 32'd0);
            end
        end
        wr_en = 1'b0;
        check("six_full_after_drop", {31'd0, full}, 32'd1);
        wait_idle(400);
        check_rx("six", 8'h01, 5);

        // Full FIFO with a write on the pop edge: write dropped.
        rx_q.delete();
        wr_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            wr_data = 8'h10 + 8'(k);
            tick();
        end
        wr_en = 1'b0;
        check("pop_full", {31'd0, full}, 32'd1);
        for (int i = 0; i < 36; i++) tick();
        check("pop_full_preedge", {31'd0, full}, 32'd1);
        wr_en = 1'b1; wr_data = 8'h77;
        tick();
        wr_en = 1'b0;
        check("pop_full_after", {31'd0, full}, 32'd0);
        check("pop_tbre_after", {31'd0, tbre}, 32'd1);
        check("pop_next_start", {31'd0, tx}, 32'd0);
        wait_idle(400);
        check_rx("pop", 8'h10, 5);

        // Reset during data bit 3 of 0xFF; a write on the reset edge is ignored.
        wr_en = 1'b1; wr_data = 8'hFF;
        tick();
        wr_en = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        rst = 1'b1; wr_en = 1'b1; wr_data = 8'h99;
        tick();
        rst = 1'b0; wr_en = 1'b0;
        check("mrst_tx", {31'd0, tx}, 32'd1);
        check("mrst_tsre", {31'd0, tsre}, 32'd1);
        check("mrst_full", {31'd0, full}, 32'd0);
        rx_q.delete();
        for (int i = 0; i < 10; i++) begin
            check("mrst_quiet_tx", {31'd0, tx}, 32'd1);
            check("mrst_quiet_tsre", {31'd0, tsre}, 32'd1);
            tick();
        end
        wr_en = 1'b1; wr_data = 8'h12;
        tick();
        wr_en = 1'b0;
        tick();
        check_frame(8'h12);
        check("mrst_tsre_end", {31'd0, tsre}, 32'd1);
        tick();
        check_rx("mrst", 8'h12, 1);
        check("stop_bit_errors", rx_bad, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
